// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared RV32I ALU: accept, one EXEC cycle, hold response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority to requester PRIO.

package alu_arbiter_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLTU = 4'd5;
    localparam logic [3:0] ALUOP_SLT  = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR,
            ALUOP_SLTU, ALUOP_SLT, ALUOP_SLL, ALUOP_SRL, ALUOP_SRA: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [3:0]  r0_op,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [3:0]  r1_op,

    output logic        rsp_valid,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,

    output logic        busy,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    state_t      state;
    state_t      state_next;
    logic        grant_id;
    logic        winner;
    logic        accept;
    logic        req_illegal;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_op;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic last;

    assign winner = ~last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant_id;
        end
    end
`else
    assign winner = PRIO;
`endif

    // NOTE: every output of a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = winner;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign sel_a  = grant_id ? r1_a  : r0_a;
    assign sel_b  = grant_id ? r1_b  : r0_b;
    assign sel_op = grant_id ? r1_op : r0_op;
    assign accept = r0_ready || r1_ready;

    // ---------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                r0_ready = r0_valid && !grant_id;
                r1_ready = r1_valid &&  grant_id;
                busy     = 1'b0;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand registers drive the ALU directly and hold between ops.
    // Illegal codes are replaced by ADD so the ALU's own default path
    // is never selected; the result is overridden at capture instead.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= ALUOP_ADD;
            req_illegal <= 1'b0;
            rsp_id      <= 1'b0;
        end else if (accept) begin
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_op      <= is_legal_op(sel_op) ? sel_op : ALUOP_ADD;
            req_illegal <= !is_legal_op(sel_op);
            rsp_id      <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            if (req_illegal) begin
                rsp_result <= '0;
                rsp_zero   <= 1'b1;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_out;
                rsp_zero   <= alu_zero;
                rsp_err    <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(r0_ready && r1_ready));

    a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result)
                                       && $stable(rsp_id) && $stable(rsp_zero)
                                       && $stable(rsp_err)));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural RV32I ALU attached.

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [3:0]  r0_op = '0, r1_op = '0;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r0_op      (r0_op),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .r1_op      (r1_op),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero)
    );

    // External combinational ALU
    always_comb begin
        case (alu_op)
            ALUOP_ADD:  alu_out = alu_a + alu_b;
            ALUOP_SUB:  alu_out = alu_a - alu_b;
            ALUOP_AND:  alu_out = alu_a & alu_b;
            ALUOP_OR:   alu_out = alu_a | alu_b;
            ALUOP_XOR:  alu_out = alu_a ^ alu_b;
            ALUOP_SLTU: alu_out = {31'b0, alu_a < alu_b};
            ALUOP_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALUOP_SLL:  alu_out = alu_a << alu_b[4:0];
            ALUOP_SRL:  alu_out = alu_a >> alu_b[4:0];
            ALUOP_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default:    alu_out = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits at a falling edge with valids driven; returns just after the accepting edge.
    task automatic wait_accept(output logic gid);
        bit seen = 1'b0;
        gid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (r0_ready || r1_ready) begin
                seen = 1'b1;
                gid  = r1_ready;
            end else begin
                @(negedge clk);
            end
        end
        check("accept_seen", seen, 1);
        @(posedge clk);
    endtask

    // Returns at falling edge + 1 of the first cycle with rsp_valid high.
    task automatic wait_rsp();
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("rsp_seen", seen, 1);
    endtask

    // One uncontended op from IDLE with rsp_ready held high; checks cycle-exact timing.
    task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [3:0] exp_alu_op, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_err);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op;
        end else begin
            r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op;
        end
        #1;
        check({tag, "_ready"}, id ? r1_ready : r0_ready, 1);
        check({tag, "_other_ready"}, id ? r0_ready : r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        #1;
        check({tag, "_exec_busy"}, busy, 1);
        check({tag, "_exec_rsp_valid"}, rsp_valid, 0);
        check({tag, "_exec_alu_a"}, alu_a, a);
        check({tag, "_exec_alu_b"}, alu_b, b);
        check({tag, "_exec_alu_op"}, alu_op, exp_alu_op);
        @(negedge clk);
        #1;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_id"}, rsp_id, id);
        check({tag, "_rsp_result"}, rsp_result, exp_res);
        check({tag, "_rsp_zero"}, rsp_zero, exp_zero);
        check({tag, "_rsp_err"}, rsp_err, exp_err);
        @(negedge clk);
        #1;
        check({tag, "_done_valid"}, rsp_valid, 0);
        check({tag, "_done_busy"}, busy, 0);
    endtask

    logic       gid;
    logic [3:0] exp_grants;

    initial begin
        // Reset state
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_readys", {r0_ready, r1_ready}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, ALUOP_ADD);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single ops
        run_op("add",  1'b0, 32'd5,        32'd7,        ALUOP_ADD,  ALUOP_ADD,  32'd12,        1'b0, 1'b0);
        run_op("slt",  1'b1, 32'hFFFF_FFFF, 32'd1,       ALUOP_SLT,  ALUOP_SLT,  32'd1,         1'b0, 1'b0);
        run_op("sltu", 1'b1, 32'hFFFF_FFFF, 32'd1,       ALUOP_SLTU, ALUOP_SLTU, 32'd0,         1'b1, 1'b0);
        run_op("sub",  1'b0, 32'd9,        32'd9,        ALUOP_SUB,  ALUOP_SUB,  32'd0,         1'b1, 1'b0);
        run_op("sra",  1'b1, 32'h8000_0000, 32'd4,       ALUOP_SRA,  ALUOP_SRA,  32'hF800_0000, 1'b0, 1'b0);
        run_op("ill",  1'b0, 32'd3,        32'd4,        4'hF,       ALUOP_ADD,  32'd0,         1'b1, 1'b1);

        // Backpressure: response held for 10 cycles, r1 waits
        @(negedge clk);
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_op = ALUOP_ADD;
        wait_accept(gid);
        check("bp_grant", gid, 0);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_a = 32'd100; r1_b = 32'd50; r1_op = ALUOP_SUB;
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 32'd3);
            check("bp_readys", {r0_ready, r1_ready}, 0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_busy", busy, 0);
        check("bp_next_ready", r1_ready, 1);
        @(posedge clk);
        wait_rsp();
        r1_valid = 1'b0;
        check("bp_next_id", rsp_id, 1);
        check("bp_next_result", rsp_result, 32'd50);

        // Contention: both valid for 4 ops
`ifdef ALU_ARB_RR_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b0000;
`endif
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd1; r0_op = ALUOP_ADD;
        r1_valid = 1'b1; r1_a = 32'd20; r1_b = 32'd2; r1_op = ALUOP_SUB;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            wait_accept(gid);
            check("cont_grant", gid, exp_grants[i]);
            wait_rsp();
            check("cont_rsp_id", rsp_id, exp_grants[i]);
            check("cont_result", rsp_result, exp_grants[i] ? 32'd18 : 32'd11);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Reset during RESP
        @(negedge clk);
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd7; r0_b = 32'd5; r0_op = ALUOP_XOR;
        wait_accept(gid);
        @(negedge clk);
        r0_valid = 1'b0;
        wait_rsp();
        check("mid_result", rsp_result, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        check("post_rst_r0_ready", r0_ready, 1);
        check("post_rst_r1_ready", r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit RV32I ALU. It accepts operation requests (a, b, 4-bit `ALUOP_*` code) over valid/ready handshakes, grants one requester at a time and drives the registered operands into the external `alu` instance. It captures `ALU_out`/`zero` and returns them to the granted requester over a valid/ready response channel. It sits between the execute-stage operand logic (requester 0) and the address/branch helper (requester 1).

## Interface
- PRIO, 0: requester that wins simultaneous requests in fixed-priority mode; ignored when round-robin is compiled in.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid / r1_valid  in  1  request valid, requester 0/1.
- r0_ready / r1_ready  out  1  request accepted this cycle when valid & ready.
- r0_a, r0_b / r1_a, r1_b  in  32  operands.
- r0_op / r1_op  in  4  `ALUOP_*` code from alu_consts.v.
- rsp_valid  out  1  response valid.
- rsp_id  out  1  requester the response belongs to.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_result  out  32  captured ALU_out.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  op code was not one of the ten defined `ALUOP_*` codes.
- busy  out  1  state != IDLE.
- alu_a, alu_b  out  32  to ALU a, b.
- alu_op  out  4  to ALU ALU_op.
- alu_out  in  32  from ALU ALU_out.
- alu_zero  in  1  from ALU zero.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant is combinational from r0_valid/r1_valid. Only the granted requester sees ready=1; ready=0 when neither is valid. On handshake, a, b, op and id are registered and the FSM moves to EXEC.
- EXEC (exactly 1 cycle): alu_a/alu_b/alu_op are driven from the registers. At the end of the cycle, alu_out and alu_zero are captured into rsp_result/rsp_zero, and the FSM moves to RESP.
- Illegal op (any code outside `ALUOP_ADD/SUB/AND/OR/XOR/SLTU/SLT/SLL/SRL/SRA`):
  - alu_op is driven as `ALUOP_ADD` so the ALU's latching default is never exercised.
  - Capture forces rsp_result=0, rsp_zero=1, rsp_err=1.
- RESP: rsp_valid=1, rsp_id=registered id, and all response fields are held stable. On rsp_ready the FSM goes to IDLE. Requests are not accepted in RESP; both readys are 0 in EXEC and RESP.
- Arbitration, single requester valid: that requester is granted regardless of mode.
- Arbitration, both valid: governed by Configuration.
- alu_a/alu_b/alu_op hold their last values outside EXEC; they are not zeroed.

## Timing
- Request accepted at edge N. EXEC occupies cycle N+1. rsp_valid=1 from cycle N+2.
- Minimum occupancy is 3 cycles per op: accept, EXEC, RESP with rsp_ready=1. The next acceptance is possible at the edge ending the following IDLE cycle.
- rsp_ready held low keeps the block in RESP indefinitely. Responses are never dropped or overwritten.
- The ALU is combinational; its result must settle within the EXEC cycle. No other path through the arbiter is combinational except the readys.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - busy=0, r0_ready=r1_ready=0.
  - alu_a=alu_b=0, alu_op=`ALUOP_ADD`.
  - Round-robin pointer last=1, so requester 0 wins first.
- Reset asserted mid-operation (EXEC or RESP): immediate return to IDLE. The in-flight op is discarded and no response is issued.
- A requester deasserting valid before handshake is legal; the grant re-evaluates each IDLE cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin.
  - When both are valid, grant the requester != last.
  - last updates only on an accepted request.
- ALU_ARB_RR_EN undefined: fixed priority. When both are valid, PRIO always wins, and requester !PRIO may starve.

## Test plan
- Single op: r0 sends a=5, b=7, op=`ALUOP_ADD` at edge 1 -> rsp_valid at cycle 3, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
- Signed compare on r1: a=32'hFFFFFFFF, b=1, op=`ALUOP_SLT` -> rsp_result=1. The same operands with `ALUOP_SLTU` -> rsp_result=0. A SUB with a=b=9 -> rsp_result=0, rsp_zero=1.
- Contention: both valid continuously for 4 ops.
  - RR build: grants 0,1,0,1.
  - Fixed build with PRIO=0: grants 0,0,0,0.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and result stable throughout, both readys 0. Release -> IDLE and the next accept one cycle later.
- Illegal op 4'hF with a=3, b=4 -> alu_op observed as `ALUOP_ADD` in EXEC, and the response is result=0, zero=1, err=1.
- Reset mid-RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid drops immediately with no clock needed, busy=0. After release, the first contended grant goes to r0.
